// File: rtl/gcd_xcel_unit.sv
// Unpipelined Euclid GCD responder on a val/rdy request/response pair.
// Swap/subtract datapath; one operand pair in flight at a time.
module gcd_xcel_unit #(
    parameter int p_nbits = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_val,
    output logic                   req_rdy,
    input  logic [2*p_nbits-1:0]   req_msg,
    output logic                   resp_val,
    input  logic                   resp_rdy,
    output logic [p_nbits-1:0]     resp_msg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [p_nbits-1:0] a_reg, b_reg;
    logic [p_nbits-1:0] a_nxt, b_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            state <= state_nxt;
            a_reg <= a_nxt;
            b_reg <= b_nxt;
        end
    end

    // Handshake outputs are pure functions of state, so there is no
    // combinational path from req_val/resp_rdy back to the ready/valid.
    always_comb begin
        state_nxt = state;
        a_nxt     = a_reg;
        b_nxt     = b_reg;
        req_rdy   = 1'b0;
        resp_val  = 1'b0;
        case (state)
            IDLE: begin
                req_rdy = 1'b1;
                if (req_val) begin
                    a_nxt     = req_msg[2*p_nbits-1:p_nbits];
                    b_nxt     = req_msg[p_nbits-1:0];
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (a_reg < b_reg) begin
                    a_nxt = b_reg;
                    b_nxt = a_reg;
                end else if (b_reg != '0) begin
                    // a_reg >= b_reg here, so the difference cannot wrap.
                    a_nxt = a_reg - b_reg;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                resp_val = 1'b1;
                if (resp_rdy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign resp_msg = a_reg;

endmodule

// File: tb/tb_gcd_xcel_unit.sv
// Directed + randomized bench for gcd_xcel_unit, checked against a modulo-based GCD model.
module tb_gcd_xcel_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_val;
    logic        req_rdy;
    logic [31:0] req_msg;
    logic        resp_val;
    logic        resp_rdy;
    logic [15:0] resp_msg;

    int tests = 0;
    int fails = 0;

    gcd_xcel_unit #(.p_nbits(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_msg  (req_msg),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_gcd(input logic [15:0] x, input logic [15:0] y);
        int a = x;
        int b = y;
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a[15:0];
    endfunction

    // One full transaction: optional source delay, accept, wait for response,
    // optional sink stall, handshake, then req_rdy must return the next cycle.
    task automatic xact(input logic [15:0] a, input logic [15:0] b, input int exp_lat,
                        input int src_d, input int snk_d, input string tag);
        logic [15:0] exp_res;
        int          cyc;
        exp_res = ref_gcd(a, b);
        for (int i = 0; i < src_d; i++) tick();
        req_val = 1'b1;
        req_msg = {a, b};
        cyc = 0;
        while (!req_rdy && cyc < 100) begin
            tick();
            cyc++;
        end
        if (!req_rdy) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
        tick();
        req_val = 1'b0;
        req_msg = $urandom;
        cyc = 1;
        while (!resp_val && cyc < 70000) begin
            tick();
            cyc++;
        end
        if (!resp_val) begin
            check({tag, "_resp_timeout"}, 32'd0, 32'd1);
            return;
        end
        if (exp_lat >= 0) check({tag, "_latency"}, cyc, exp_lat);
        for (int i = 0; i < snk_d; i++) begin
            check({tag, "_stall_val"}, {31'd0, resp_val}, 32'd1);
            check({tag, "_stall_msg"}, {16'd0, resp_msg}, {16'd0, exp_res});
            tick();
        end
        resp_rdy = 1'b1;
        check({tag, "_result"}, {16'd0, resp_msg}, {16'd0, exp_res});
        check({tag, "_rdy_in_done"}, {31'd0, req_rdy}, 32'd0);
        tick();
        resp_rdy = 1'b0;
        check({tag, "_rdy_after"}, {31'd0, req_rdy}, 32'd1);
    endtask

    initial begin
        int          cyc;
        logic        saw_val;
        logic [15:0] x, y, g;

        reset    = 1'b1;
        req_val  = 1'b1;
        req_msg  = 32'h0003_0006;
        resp_rdy = 1'b0;
        tick();
        tick();
        reset   = 1'b0;
        req_val = 1'b0;
        check("reset_req_rdy", {31'd0, req_rdy}, 32'd1);
        check("reset_resp_val", {31'd0, resp_val}, 32'd0);
        check("reset_resp_msg", {16'd0, resp_msg}, 32'd0);
        tick();
        check("no_accept_in_reset", {31'd0, req_rdy}, 32'd1);

        // Abort mid-CALC: accept ends cycle 0, reset asserted in cycle 3.
        req_val = 1'b1;
        req_msg = 32'h000F_0005;
        tick();
        req_val = 1'b0;
        saw_val = 1'b0;
        tick();
        saw_val |= resp_val;
        tick();
        saw_val |= resp_val;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            saw_val |= resp_val;
            tick();
        end
        check("abort_no_resp", {31'd0, saw_val}, 32'd0);
        check("abort_req_rdy", {31'd0, req_rdy}, 32'd1);
        check("abort_resp_msg", {16'd0, resp_msg}, 32'd0);
        xact(16'h0007, 16'h0000, 2, 0, 0, "after_abort");

        // Directed latency/result cases.
        xact(16'h000F, 16'h0005, 6, 0, 0, "basic");
        xact(16'h001B, 16'h000F, 11, 0, 0, "mixed");
        xact(16'h0000, 16'h0007, 3, 0, 0, "zero_a");
        xact(16'h0000, 16'h0000, 2, 0, 0, "zero_both");
        xact(16'h0009, 16'h0000, 2, 0, 0, "zero_b");
        xact(16'hFFFF, 16'hFFFF, 4, 1, 2, "ffff_ffff");

        // Backpressure with a second request held on the source side;
        // the first message is changed right after accept and must not matter.
        resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
        req_val  = 1'b1;
        req_msg  = 32'h0024_0010;
        tick();
        req_msg = 32'h0009_0000;
        cyc = 1;
        while (!resp_val && cyc < 200) begin
            check("bp_rdy_calc", {31'd0, req_rdy}, 32'd0);
            tick();
            cyc++;
        end
        check("bp_resp_seen", {31'd0, resp_val}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            check("bp_val", {31'd0, resp_val}, 32'd1);
            check("bp_msg", {16'd0, resp_msg}, 32'h0004);
            check("bp_req_rdy", {31'd0, req_rdy}, 32'd0);
            tick();
        end
        resp_rdy = 1'b1;
        check("bp_msg_hs", {16'd0, resp_msg}, 32'h0004);
        tick();
        resp_rdy = 1'b0;
        check("bp_rdy_after", {31'd0, req_rdy}, 32'd1);
        tick();
        req_val = 1'b0;
        check("bp_second_accepted", {31'd0, req_rdy}, 32'd0);
        cyc = 1;
        while (!resp_val && cyc < 200) begin
            tick();
            cyc++;
        end
        check("bp_second_lat", cyc, 32'd2);
        check("bp_second_msg", {16'd0, resp_msg}, 32'h0009);
        resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;

        // Worst case: one swap + 65535 subtracts + detection cycle.
        xact(16'hFFFF, 16'h0001, 65538, 0, 0, "worst");
        xact(16'h0001, 16'hFFFF, -1, 0, 0, "worst_sw_short");

        // Random stream: operands share a random factor with small cofactors,
        // keeping the subtract count bounded while spanning the 16-bit range.
        for (int n = 0; n < 1000; n++) begin
            g = 16'($urandom_range(1, 4095));
            x = 16'($urandom_range(0, 15));
            y = 16'($urandom_range(0, 15));
            xact(16'(g * x), 16'(g * y), -1, $urandom_range(0, 2), $urandom_range(0, 2), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gcd_xcel_unit.md
# gcd_xcel_unit

Iterative Euclid GCD responder that sits on the far end of the host request/response val/rdy interface. It accepts one packed operand pair per request, computes the GCD with a swap/subtract datapath, and returns a `p_nbits`-wide result. It is the unit the host-side shim and the test source/sink drive. It is unpipelined: one transaction is in flight at a time.

## Interface
- `p_nbits`, default 16, operand and result width; the request is 2*`p_nbits` bits.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_val`  in  1  request valid.
- `req_rdy`  out  1  request ready.
- `req_msg`  in  2*p_nbits  operand A in [2p-1:p], operand B in [p-1:0].
- `resp_val`  out  1  response valid.
- `resp_rdy`  in  1  response ready.
- `resp_msg`  out  p_nbits  GCD result.

## Operation
- State registers:
  - FSM state: IDLE, CALC or DONE.
  - Operand registers `a_reg` and `b_reg`, each `p_nbits` wide.
- IDLE:
  - `req_rdy`=1, `resp_val`=0.
  - On `req_val`&&`req_rdy`: load `a_reg`=A and `b_reg`=B, then go to CALC.
- CALC (`req_rdy`=0, `resp_val`=0). One action per cycle, checked in this priority order:
  - `a_reg` < `b_reg` (unsigned): swap `a_reg` and `b_reg`.
  - else `b_reg` != 0: `a_reg` <= `a_reg` - `b_reg`. This never underflows, and there is no carry out.
  - else (`b_reg`==0): go to DONE; registers unchanged.
- DONE:
  - `resp_val`=1, `req_rdy`=0.
  - On `resp_val`&&`resp_rdy`: go to IDLE.
  - Otherwise hold; `resp_msg` stays stable while `resp_val` is high.
- `resp_msg` = `a_reg` combinationally in all states. It is meaningful only when `resp_val`=1.
- Zero-operand cases:
  - gcd(0,0)=0.
  - gcd(x,0)=x.
  - gcd(0,y)=y, via one swap.
- No request is accepted while in CALC or DONE. `req_val` may be held high; it is ignored there.
- `req_msg` is sampled only on the accept edge. Later changes to it have no effect.

## Timing
- Reset:
  - state=IDLE, `a_reg`=`b_reg`=0.
  - Outputs: `req_rdy`=1, `resp_val`=0, `resp_msg`=0.
  - Reset asserted in any state, including mid-CALC or DONE with `resp_val` high, aborts the transaction. Nothing is emitted for it.
  - While `reset` is high, no request is accepted, even if `req_val`=1.
- Latency: let S be the number of swap+subtract steps, with the request accepted at the edge ending cycle 0.
  - Cycles 1..S+1 are CALC. The final CALC cycle is the `b_reg`==0 detection cycle.
  - `resp_val` is high from cycle S+2. Latency = S+2 cycles.
- Response handshake: accepted at the first rising edge with `resp_val`&&`resp_rdy`. `req_rdy` goes high in the following cycle.
- Back-to-back throughput: the minimum spacing between accepts is S+3 cycles.
- `resp_rdy` high before DONE has no effect.
- `resp_rdy` low in DONE stalls the unit indefinitely, with no loss of the result.
- Worst case at `p_nbits`=16 is gcd(0xFFFF,1):
  - S = 65535 subtracts + 1 swap.
  - Latency = 65538 cycles.
  - Required to terminate with result 1.
- No combinational path from `req_val` to `req_rdy`, or from `resp_rdy` to `resp_val`; both ready/valid outputs depend only on state.

## Test plan
- Reset mid-run: apply reset → `req_rdy`=1, `resp_val`=0, `resp_msg`=0. Send req 0x000F0005; assert reset in cycle 3 → no response is produced and `req_rdy`=1 after reset. A following req 0x00070000 yields 7.
- Basic: req 0x000F0005 (15,5) with sink always ready → resp 0x0005. `resp_val` rises 6 cycles after accept (S=4).
- Mixed swaps: req 0x001B000F (27,15) → resp 0x0003, latency 11 (S=9). Req 0x00000007 (0,7) → resp 0x0007, latency 3.
- Zeros: req 0x00000000 → resp 0x0000, latency 2. Req 0x00090000 → resp 0x0009, latency 2.
- Sink backpressure:
  - req (0x0024,0x0010) → resp 0x0004.
  - With `resp_rdy` held low 10 cycles, `resp_val` and `resp_msg` stay stable.
  - `req_rdy` stays 0 while `req_val` is held high with a second request. The second request is accepted only in the cycle after the response handshake.
- Random stream:
  - Run 1000 random 16-bit pairs with random source and sink delays, checked against a reference GCD model.
  - Include (0xFFFF,0xFFFF)→0xFFFF and (0xFFFF,1)→0x0001, the latter taking latency 65538.
